// File: rtl/acsi_initiator.sv
// ACSI bus initiator: sends a 6/10/12/16-byte command from a 16-entry buffer
// to a target, one sel strobe per byte with an irq handshake, then reads the
// status byte. Every bus step and timeout advances only on clk_en ticks.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   clk_en            bus-timing enable
//   cmd_wr/addr/data  command buffer write port (ignored while busy)
//   start, target     launch a transfer to target id (ignored while busy)
//   busy, done        transfer in progress / one-cycle end pulse
//   status            status byte from target (8'hff on timeout)
//   timeout_err       last transfer ended by timeout
//   acsi_a1/sel/rw    bus control lines
//   acsi_dout         byte driven to the target
//   acsi_din          byte returned by the target
//   acsi_irq          target interrupt / byte acknowledge
module acsi_initiator #(
    parameter int unsigned BYTE_TIMEOUT = 1000,
    parameter int unsigned CMD_TIMEOUT  = 2000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_en,
    input  logic       cmd_wr,
    input  logic [3:0] cmd_addr,
    input  logic [7:0] cmd_data,
    input  logic       start,
    input  logic [2:0] target,
    output logic       busy,
    output logic       done,
    output logic [7:0] status,
    output logic       timeout_err,
    output logic       acsi_a1,
    output logic       acsi_sel,
    output logic       acsi_rw,
    output logic [7:0] acsi_dout,
    input  logic [7:0] acsi_din,
    input  logic       acsi_irq
);
    localparam int unsigned MAX_TMO = (CMD_TIMEOUT > BYTE_TIMEOUT) ? CMD_TIMEOUT : BYTE_TIMEOUT;
    localparam int unsigned CNT_W   = (MAX_TMO < 2) ? 2 : $clog2(MAX_TMO + 1);
    localparam int unsigned CNT_W1  = CNT_W + 1;
    localparam int unsigned IDX_W   = 5;

    typedef enum logic [2:0] {
        IDLE, SEL, GAP, WAIT_IRQ, STAT_SEL, STAT_GAP, FIN
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [2:0]         tgt_q, tgt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         status_d;
    logic               tmo_d;
    logic               busy_d, done_d, sel_d, rw_d, a1_d;
    logic [7:0]         dout_d;

    logic [7:0]         cmd_buf [16];
    logic [7:0]         op_fwd;
    logic               icd;
    logic [IDX_W-1:0]   cmd_len, n_bytes;
    logic               last_byte;
    logic [CNT_W-1:0]   limit;
    logic               expired;
    logic [3:0]         buf_idx;
    logic [7:0]         byte_d;

    // Command buffer; contents are not reset.
    always_ff @(posedge clk) begin
        if (cmd_wr && state_q == IDLE) begin
            cmd_buf[cmd_addr] <= cmd_data;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            tgt_q       <= '0;
            cnt_q       <= '0;
            status      <= '0;
            timeout_err <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            acsi_sel    <= 1'b0;
            acsi_rw     <= 1'b1;
            acsi_a1     <= 1'b1;
            acsi_dout   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            tgt_q       <= tgt_d;
            cnt_q       <= cnt_d;
            status      <= status_d;
            timeout_err <= tmo_d;
            busy        <= busy_d;
            done        <= done_d;
            acsi_sel    <= sel_d;
            acsi_rw     <= rw_d;
            acsi_a1     <= a1_d;
            acsi_dout   <= dout_d;
        end
    end

    // Next state, datapath and next output values.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        tgt_d    = tgt_q;
        cnt_d    = cnt_q;
        status_d = status;
        tmo_d    = timeout_err;

        // A write to entry 0 coinciding with start must be seen by this transfer.
        op_fwd = (state_q == IDLE && cmd_wr && cmd_addr == 4'd0) ? cmd_data : cmd_buf[0];
        icd    = (op_fwd > 8'h1f);

        if (op_fwd < 8'h20)             cmd_len = IDX_W'(6);
        else if (op_fwd < 8'h60)        cmd_len = IDX_W'(10);
        else if (op_fwd[7:5] == 3'b100) cmd_len = IDX_W'(16);
        else                            cmd_len = IDX_W'(12);

        // ICD commands carry an extra escape byte ahead of the opcode.
        n_bytes   = cmd_len + IDX_W'(icd);
        last_byte = (idx_q == n_bytes - IDX_W'(1));
        limit     = last_byte ? CNT_W'(CMD_TIMEOUT) : CNT_W'(BYTE_TIMEOUT);
        expired   = ({1'b0, cnt_q} + CNT_W1'(1)) >= {1'b0, limit};

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SEL;
                    idx_d   = '0;
                    tgt_d   = target;
                    tmo_d   = 1'b0;
                end
            end
            SEL: begin
                if (clk_en) state_d = GAP;
            end
            GAP: begin
                if (clk_en) begin
                    state_d = WAIT_IRQ;
                    cnt_d   = '0;
                end
            end
            WAIT_IRQ: begin
                if (clk_en) begin
                    if (acsi_irq) begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = last_byte ? STAT_SEL : SEL;
                    end else if (expired) begin
                        tmo_d    = 1'b1;
                        status_d = 8'hff;
                        state_d  = FIN;
                    end else if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            STAT_SEL: begin
                if (clk_en) begin
                    status_d = acsi_din;
                    state_d  = STAT_GAP;
                end
            end
            STAT_GAP: begin
                if (clk_en) state_d = FIN;
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Byte for the next index: first byte is {target, opcode-or-escape}.
        buf_idx = icd ? 4'(idx_d - IDX_W'(1)) : 4'(idx_d);
        byte_d  = (idx_d == '0) ? {tgt_d, (icd ? 5'h1f : op_fwd[4:0])} : cmd_buf[buf_idx];

        busy_d = (state_d != IDLE);
        done_d = (state_d == FIN);
        sel_d  = (state_d == SEL) || (state_d == STAT_SEL);
        rw_d   = (state_d != SEL);
        a1_d   = !((state_d == SEL) && (idx_d == '0));
        dout_d = (state_d == SEL) ? byte_d : acsi_dout;
    end

endmodule

// File: tb/tb_acsi_initiator.sv
module tb_acsi_initiator;
    localparam int unsigned BT = 20;
    localparam int unsigned CT = 80;

    logic       clk = 1'b0;
    logic       reset, clk_en, cmd_wr, start;
    logic [3:0] cmd_addr;
    logic [7:0] cmd_data;
    logic [2:0] target;
    logic       busy, done, timeout_err, acsi_a1, acsi_sel, acsi_rw, acsi_irq;
    logic [7:0] status, acsi_dout, acsi_din;

    acsi_initiator #(.BYTE_TIMEOUT(BT), .CMD_TIMEOUT(CT)) dut (
        .clk(clk), .reset(reset), .clk_en(clk_en), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .start(start), .target(target),
        .busy(busy), .done(done), .status(status), .timeout_err(timeout_err),
        .acsi_a1(acsi_a1), .acsi_sel(acsi_sel), .acsi_rw(acsi_rw),
        .acsi_dout(acsi_dout), .acsi_din(acsi_din), .acsi_irq(acsi_irq)
    );

    always #5 clk = ~clk;

    typedef logic [8:0] bq_t[$];

    int tests = 0;
    int fails = 0;

    // Bus agent configuration and observations.
    int   en_mode = 0;       // 0 always on, 1 random, 2 held low
    int   ack_delay = 1;
    int   final_delay = 1;
    int   stop_at = -1;      // byte index from which the target stops acking
    int   n_exp = 0;
    bq_t  cap_q;
    int   stat_reads = 0;
    int   since = 0;
    int   since_at_done = -1;
    int   done_cycles = 0;
    int   viol = 0;
    bit   prev_sel_tick = 0;
    bit   acking = 1;
    int   need = 1;
    logic [7:0] shadow [16];
    logic te_after_start, busy_after_start;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural target: records each write byte, acks after a delay, counts status reads.
    initial begin
        clk_en   = 1'b0;
        acsi_irq = 1'b0;
        acsi_din = 8'h00;
        forever begin
            @(negedge clk);
            if (done) begin
                done_cycles++;
                since_at_done = since;
            end
            case (en_mode)
                0:       clk_en = 1'b1;
                1:       clk_en = 1'($urandom_range(0, 1));
                default: clk_en = 1'b0;
            endcase
            if (clk_en && !reset) begin
                if (acsi_sel && prev_sel_tick) viol++;
                if (!acsi_a1 && !(acsi_sel && !acsi_rw)) viol++;
                if (acsi_sel && acsi_rw && !acsi_a1) viol++;
                prev_sel_tick = acsi_sel;
                if (acsi_sel && !acsi_rw) begin
                    acking = !(stop_at >= 0 && cap_q.size() >= stop_at);
                    need   = (cap_q.size() == n_exp - 1) ? final_delay : ack_delay;
                    cap_q.push_back({acsi_a1, acsi_dout});
                    since    = 0;
                    acsi_irq = 1'b0;
                end else begin
                    if (acsi_sel) stat_reads++;
                    since++;
                    if (acking && since >= need) acsi_irq = 1'b1;
                end
            end
        end
    end

    // Reference: command byte sequence from the opcode-length rules.
    function automatic bq_t model_bytes(input logic [2:0] t);
        bq_t q;
        int len;
        logic [7:0] op;
        op = shadow[0];
        if (op <= 8'h1f)                    len = 6;
        else if (op <= 8'h5f)               len = 10;
        else if (op >= 8'h80 && op <= 8'h9f) len = 16;
        else                                len = 12;
        if (op <= 8'h1f) begin
            q.push_back({1'b0, t, op[4:0]});
            for (int i = 1; i < len; i++) q.push_back({1'b1, shadow[i]});
        end else begin
            q.push_back({1'b0, t, 5'h1f});
            for (int i = 0; i < len; i++) q.push_back({1'b1, shadow[i]});
        end
        return q;
    endfunction

    task automatic load_buf();
        for (int i = 0; i < 16; i++) begin
            cmd_wr = 1'b1; cmd_addr = 4'(i); cmd_data = shadow[i];
            @(negedge clk);
        end
        cmd_wr = 1'b0;
    endtask

    task automatic start_xfer(input logic [2:0] t, input bit co_wr, input logic [7:0] co_data);
        cap_q.delete();
        stat_reads = 0; done_cycles = 0; viol = 0; prev_sel_tick = 0;
        since = 0; since_at_done = -1;
        target = t; start = 1'b1;
        if (co_wr) begin
            cmd_wr = 1'b1; cmd_addr = 4'd0; cmd_data = co_data;
        end
        @(negedge clk);
        start = 1'b0; cmd_wr = 1'b0; target = 3'($urandom);
        te_after_start   = timeout_err;
        busy_after_start = busy;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 0;
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            if (done) begin seen = 1; break; end
        end
        check({tag, ".done_seen"}, int'(seen), 1);
        @(negedge clk);
    endtask

    task automatic verify(input string tag, input bq_t exp_q, input logic [7:0] exp_st,
                          input bit exp_to, input int exp_since);
        check({tag, ".nbytes"}, cap_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
            check($sformatf("%s.byte%0d", tag, i), int'(cap_q[i]), int'(exp_q[i]));
        check({tag, ".status"}, int'(status), int'(exp_st));
        check({tag, ".timeout_err"}, int'(timeout_err), int'(exp_to));
        check({tag, ".done_pulses"}, done_cycles, 1);
        check({tag, ".status_reads"}, stat_reads, exp_to ? 0 : 1);
        check({tag, ".bus_rules"}, viol, 0);
        check({tag, ".busy_after"}, int'(busy), 0);
        if (exp_to) check({tag, ".timeout_ticks"}, since_at_done, exp_since);
    endtask

    typedef struct {
        logic [7:0] op;
        logic [2:0] tgt;
        logic [7:0] din;
        int         nb;
        logic [7:0] first;
    } vec_t;

    vec_t vecs[12];

    initial begin
        bq_t exp_q;
        int snap;

        vecs[0]  = '{8'h08, 3'd1, 8'h00, 6,  8'h28};
        vecs[1]  = '{8'h1f, 3'd7, 8'h02, 6,  8'hff};
        vecs[2]  = '{8'h00, 3'd0, 8'h5a, 6,  8'h00};
        vecs[3]  = '{8'h20, 3'd2, 8'h01, 11, 8'h5f};
        vecs[4]  = '{8'h5f, 3'd3, 8'h80, 11, 8'h7f};
        vecs[5]  = '{8'h25, 3'd0, 8'h00, 11, 8'h1f};
        vecs[6]  = '{8'h60, 3'd4, 8'h33, 13, 8'h9f};
        vecs[7]  = '{8'h7f, 3'd5, 8'hc4, 13, 8'hbf};
        vecs[8]  = '{8'h80, 3'd6, 8'h02, 17, 8'hdf};
        vecs[9]  = '{8'h9f, 3'd1, 8'h11, 17, 8'h3f};
        vecs[10] = '{8'ha0, 3'd2, 8'hfe, 13, 8'h5f};
        vecs[11] = '{8'hff, 3'd3, 8'h07, 13, 8'h7f};

        reset = 1'b1; cmd_wr = 1'b0; cmd_addr = '0; cmd_data = '0;
        start = 1'b0; target = '0;
        repeat (3) @(negedge clk);
        check("rst.busy", int'(busy), 0);
        check("rst.done", int'(done), 0);
        check("rst.sel", int'(acsi_sel), 0);
        check("rst.rw", int'(acsi_rw), 1);
        check("rst.a1", int'(acsi_a1), 1);
        check("rst.dout", int'(acsi_dout), 0);
        check("rst.status", int'(status), 0);
        check("rst.timeout_err", int'(timeout_err), 0);
        reset = 1'b0;
        @(negedge clk);

        // Opcode classes and length table.
        for (int v = 0; v < 12; v++) begin
            for (int i = 0; i < 16; i++) shadow[i] = 8'($urandom);
            shadow[0] = vecs[v].op;
            load_buf();
            n_exp = vecs[v].nb; stop_at = -1;
            ack_delay = $urandom_range(1, 4); final_delay = $urandom_range(1, 10);
            acsi_din = vecs[v].din; en_mode = v % 2;
            start_xfer(vecs[v].tgt, 0, 8'h00);
            check($sformatf("vec%0d.busy_on_start", v), int'(busy_after_start), 1);
            wait_done($sformatf("vec%0d", v));
            check($sformatf("vec%0d.table_len", v), cap_q.size(), vecs[v].nb);
            if (cap_q.size() > 0)
                check($sformatf("vec%0d.table_first", v), int'(cap_q[0]), int'({1'b0, vecs[v].first}));
            verify($sformatf("vec%0d", v), model_bytes(vecs[v].tgt), vecs[v].din, 0, 0);
        end

        // Example 6-byte command with a slow completion, status 0x00 then 0x02.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 16; i++) shadow[i] = 8'($urandom);
            shadow[0] = 8'h08; shadow[1] = 8'h00; shadow[2] = 8'h00;
            shadow[3] = 8'h05; shadow[4] = 8'h01; shadow[5] = 8'h00;
            load_buf();
            n_exp = 6; stop_at = -1; ack_delay = 1; final_delay = 50;
            acsi_din = (r == 0) ? 8'h00 : 8'h02; en_mode = r;
            start_xfer(3'd1, 0, 8'h00);
            wait_done($sformatf("ex%0d", r));
            exp_q = '{9'h028, 9'h100, 9'h100, 9'h105, 9'h101, 9'h100};
            verify($sformatf("ex%0d", r), exp_q, (r == 0) ? 8'h00 : 8'h02, 0, 0);
        end

        // Write to entry 0 in the same cycle as start: new opcode must be used.
        for (int i = 0; i < 16; i++) shadow[i] = 8'($urandom);
        shadow[0] = 8'h08;
        load_buf();
        shadow[0] = 8'h25;
        n_exp = 11; stop_at = -1; ack_delay = 2; final_delay = 3;
        acsi_din = 8'h44; en_mode = 0;
        start_xfer(3'd3, 1, 8'h25);
        wait_done("cowr");
        verify("cowr", model_bytes(3'd3), 8'h44, 0, 0);

        // Target stops acking after byte 3: byte timeout.
        for (int i = 0; i < 16; i++) shadow[i] = 8'($urandom);
        shadow[0] = 8'h0a;
        load_buf();
        n_exp = 6; stop_at = 3; ack_delay = 1; en_mode = 1;
        start_xfer(3'd5, 0, 8'h00);
        wait_done("tmo");
        exp_q = model_bytes(3'd5);
        while (exp_q.size() > 4) void'(exp_q.pop_back());
        verify("tmo", exp_q, 8'hff, 1, 1 + BT);

        // Next start clears timeout_err; last byte never acked gives command timeout.
        stop_at = 5; en_mode = 0;
        start_xfer(3'd5, 0, 8'h00);
        check("tmo_clear_on_start", int'(te_after_start), 0);
        wait_done("cmdtmo");
        verify("cmdtmo", model_bytes(3'd5), 8'hff, 1, 1 + CT);

        // Reset during the wait for byte 2's acknowledge.
        n_exp = 6; stop_at = 2; ack_delay = 1; en_mode = 0;
        start_xfer(3'd2, 0, 8'h00);
        for (int c = 0; c < 2000 && cap_q.size() < 3; c++) @(negedge clk);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort.busy", int'(busy), 0);
        check("abort.sel", int'(acsi_sel), 0);
        check("abort.done", int'(done), 0);
        repeat (5) @(negedge clk);
        check("abort.no_done", done_cycles, 0);
        for (int i = 0; i < 16; i++) shadow[i] = 8'($urandom);
        shadow[0] = 8'h03;
        load_buf();
        stop_at = -1; acsi_din = 8'h21;
        start_xfer(3'd2, 0, 8'h00);
        wait_done("after_abort");
        verify("after_abort", model_bytes(3'd2), 8'h21, 0, 0);

        // Start while busy is dropped; nothing moves while clk_en is low.
        stop_at = 2; en_mode = 1;
        start_xfer(3'd6, 0, 8'h00);
        for (int c = 0; c < 2000 && cap_q.size() < 3; c++) @(negedge clk);
        en_mode = 2;
        @(negedge clk);
        snap = since;
        start = 1'b1; target = 3'd1;
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        check("hold.nbytes", cap_q.size(), 3);
        check("hold.ticks", since, snap);
        check("hold.busy", int'(busy), 1);
        check("hold.no_done", done_cycles, 0);
        en_mode = 1;
        wait_done("hold");
        exp_q = model_bytes(3'd6);
        while (exp_q.size() > 3) void'(exp_q.pop_back());
        verify("hold", exp_q, 8'hff, 1, 1 + BT);
        repeat (10) @(negedge clk);
        check("hold.second_start_dropped", int'(busy) + cap_q.size(), 3);

        // Randomized transfers against the reference model.
        for (int r = 0; r < 16; r++) begin
            logic [2:0] t;
            bit to;
            for (int i = 0; i < 16; i++) shadow[i] = 8'($urandom);
            load_buf();
            t = 3'($urandom);
            exp_q = model_bytes(t);
            n_exp = exp_q.size();
            stop_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n_exp - 1)) : -1;
            to = (stop_at >= 0);
            ack_delay = $urandom_range(1, 5); final_delay = $urandom_range(1, 20);
            acsi_din = 8'($urandom); en_mode = $urandom_range(0, 1);
            start_xfer(t, 0, 8'h00);
            wait_done($sformatf("rnd%0d", r));
            if (to) while (exp_q.size() > stop_at + 1) void'(exp_q.pop_back());
            verify($sformatf("rnd%0d", r), exp_q, to ? 8'hff : acsi_din, to,
                   1 + ((stop_at == n_exp - 1) ? int'(CT) : int'(BT)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
